dmem_access_ctrl: RTL and testbench

Sequencer between the EX/MEM stage and a multi-cycle data memory. It accepts one load or store per access from the EX/MEM outputs and stalls the pipeline while it drives a req/ack handshake to the memory. It returns load data with its destination register to the MEM/WB path, and aborts hung accesses with a watchdog.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_watchdog.sv | 38 +++
 rtl/dmem_access_ctrl.sv | 101 ++++++++++
 tb/tb_dmem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access sequencer: EX/MEM op codes,
// FSM state encoding and the default watchdog limit.
package dmem_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_LDX  = 2'b01;
    localparam logic [1:0] MEM_LD   = 2'b10;
    localparam logic [1:0] MEM_ST   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int TIMER_W         = 8;

endpackage

// File: rtl/dmem_watchdog.sv
// Counts enabled cycles and flags the cycle in which the TIMEOUT-th enabled
// cycle occurs; TIMEOUT = 0 removes the counter entirely.
module dmem_watchdog
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk_i, rst_i, clr_i, en_i};
            assign expired_o     = 1'b0;
        end else begin : g_on
            localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);
            logic [TIMER_W-1:0] count_reg;

            always_ff @(posedge clk_i) begin
                if (!rst_i || clr_i) begin
                    count_reg <= '0;
                end else if (en_i) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            // Fires while the count is about to reach TIMEOUT, so the request
            // is held for exactly TIMEOUT cycles before the abort.
            assign expired_o = en_i && (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences one EX/MEM load/store into a req/ack data memory, stalling the
// pipeline while busy and returning load data to MEM/WB.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mem_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              wb_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o
);

    dmem_state_t state_reg;
    logic        wb_en_reg;
    logic        timer_clr;
    logic        timer_en;
    logic        expired;

    assign timer_clr = (state_reg != ST_BUSY) || mem_ack_i;
    assign timer_en  = (state_reg == ST_BUSY) && !mem_ack_i;

    dmem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (expired)
    );

    // DONE deasserts stall so the frozen EX/MEM op drains without reissue.
    assign stall_o = ((state_reg == ST_IDLE) && (mem_op_i != MEM_NONE))
                   || (state_reg == ST_BUSY);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg   <= ST_IDLE;
            wb_en_reg   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            wb_valid_o  <= 1'b0;
            wb_rd_o     <= '0;
            wb_data_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            err_o      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (mem_op_i != MEM_NONE) begin
                        state_reg   <= ST_BUSY;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= (mem_op_i == MEM_ST);
                        mem_addr_o  <= addr_i;
                        mem_wdata_o <= wdata_i;
                        wb_rd_o     <= rd_addr_i;
                        wb_en_reg   <= wb_i;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack_i) begin
                        state_reg  <= ST_DONE;
                        mem_req_o  <= 1'b0;
                        if (!mem_we_o) begin
                            wb_data_o <= mem_rdata_i;
                        end
                        wb_valid_o <= !mem_we_o && wb_en_reg && (wb_rd_o != 5'd0);
                    end else if (expired) begin
                        state_reg <= ST_DONE;
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomised bench: a driver plays EX/MEM and memory, queues the expected
// MEM/WB or abort pulse, and a monitor pops and compares each pulse.
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_addr_i;
    logic        wb_i;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    dmem_access_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .mem_op_i    (mem_op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rd_addr_i   (rd_addr_i),
        .wb_i        (wb_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .wb_valid_o  (wb_valid_o),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [4:0]  rd;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wb_valid_o === 1'b1 || err_o === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_pulse: got wb_valid=%0b err=%0b at cycle %0d, expected none",
                         wb_valid_o, err_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", 64'({wb_valid_o, err_o}), e.is_err ? 64'd1 : 64'd2);
                chk("pulse_cycle", 64'(cyc), 64'(e.at));
                if (!e.is_err) begin
                    chk("wb_rd", 64'(wb_rd_o), 64'(e.rd));
                    chk("wb_data", 64'(wb_data_o), 64'(e.data));
                end
            end
        end
    end

    // One access from the first presentation of the op through its DONE cycle.
    // k = cycle offset of the ack; an ack beyond TO (or k = 0) never arrives in time.
    task automatic do_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input logic wb, input int k,
                          input logic [31:0] rdat);
        int  t0;
        bit  acked;
        bit  is_load;
        int  last;
        t0      = cyc;
        acked   = (k >= 1) && (k <= TO);
        is_load = (op != 2'b11);
        last    = acked ? k : TO;
        if (!acked) begin
            sb.push_back('{is_err: 1'b1, rd: 5'd0, data: 32'd0, at: t0 + last + 1});
        end else if (is_load && wb && rd != 5'd0) begin
            sb.push_back('{is_err: 1'b0, rd: rd, data: rdat, at: t0 + last + 1});
        end
        $display("txn op=%0d addr=%h wdata=%h rd=%0d wb=%0b ack_k=%0d rdata=%h start=%0d",
                 op, a, wd, rd, wb, k, rdat, t0);
        mem_op_i  = op;
        addr_i    = a;
        wdata_i   = wd;
        rd_addr_i = rd;
        wb_i      = wb;
        for (int c = 0; c <= last + 1; c++) begin
            mem_ack_i   = (c == k);
            mem_rdata_i = (c == k) ? rdat : $urandom;
            @(negedge clk);
            chk("stall", 64'(stall_o), 64'(c <= last));
            chk("mem_req", 64'(mem_req_o), 64'(c >= 1 && c <= last));
            if (c >= 1 && c <= last) begin
                chk("mem_we", 64'(mem_we_o), 64'(op == 2'b11));
                chk("mem_addr", 64'(mem_addr_o), 64'(a));
                chk("mem_wdata", 64'(mem_wdata_o), 64'(wd));
            end
            @(posedge clk);
            #1;
        end
        mem_ack_i = 1'b0;
        mem_op_i  = 2'b00;
        addr_i    = $urandom;
        wdata_i   = $urandom;
    endtask

    task automatic idle(input int n, input bit spurious);
        for (int i = 0; i < n; i++) begin
            mem_op_i    = 2'b00;
            mem_ack_i   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata_i = $urandom;
            @(negedge clk);
            chk("idle_stall", 64'(stall_o), 64'd0);
            chk("idle_req", 64'(mem_req_o), 64'd0);
            @(posedge clk);
            #1;
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk(nm, {mem_req_o, mem_we_o, wb_valid_o, err_o, wb_rd_o, stall_o}, 64'd0);
        chk({nm, "_data"}, {mem_addr_o, mem_wdata_o}, 64'd0);
        chk({nm, "_wbdata"}, 64'(wb_data_o), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before bound");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b0;
        mem_op_i    = 2'b10;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        rd_addr_i   = 5'd0;
        wb_i        = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_stall_follows_op", 64'(stall_o), 64'd1);
        chk("reset_regs", {mem_req_o, mem_we_o, wb_valid_o, err_o, wb_rd_o}, 64'd0);
        chk("reset_data", {mem_addr_o, mem_wdata_o}, 64'd0);
        chk("reset_wbdata", 64'(wb_data_o), 64'd0);
        @(posedge clk);
        #1;
        mem_op_i = 2'b00;
        rst_i    = 1'b1;
        idle(2, 1'b0);

        // Directed cases
        do_txn(2'b10, 32'h100, 32'h0, 5'd5, 1'b1, 3, 32'hDEADBEEF);
        idle(1, 1'b0);
        do_txn(2'b11, 32'h40, 32'h12345678, 5'd7, 1'b1, 1, 32'hCAFEF00D);
        idle(1, 1'b0);
        do_txn(2'b10, 32'h200, 32'h0, 5'd9, 1'b1, 0, 32'h0);
        idle(1, 1'b0);
        do_txn(2'b01, 32'h300, 32'h0, 5'd0, 1'b1, 2, 32'h55AA55AA);
        idle(3, 1'b1);
        do_txn(2'b10, 32'h304, 32'h0, 5'd12, 1'b1, TO, 32'h0BADF00D);
        idle(1, 1'b0);

        // Reset while busy: op accepted, reset at the start of BUSY cycle 2
        $display("txn reset_in_busy start=%0d", cyc);
        mem_op_i  = 2'b10;
        addr_i    = 32'h500;
        rd_addr_i = 5'd6;
        wb_i      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_i    = 1'b0;
        mem_op_i = 2'b00;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        check_all_zero("reset_in_busy");
        @(posedge clk);
        #1;
        idle(3, 1'b1);

        // Back-to-back loads, each acked at k=1
        do_txn(2'b10, 32'h600, 32'h0, 5'd3, 1'b1, 1, 32'h11112222);
        do_txn(2'b10, 32'h604, 32'h0, 5'd4, 1'b1, 1, 32'h33334444);
        idle(1, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [4:0] rd;
            int         k;
            op = 2'($urandom_range(1, 3));
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            k  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 1);
            do_txn(op, $urandom, $urandom, rd, 1'($urandom_range(0, 1)), k, $urandom);
            idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        idle(3, 1'b0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
